// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences datapath mux selects and write enables per instruction.
// Latency: branch 3, ALU/LUI/AUIPC/JAL/store 4, load/JALR 5 cycles with zero memory wait states.
// Backpressure: with MEM_HANDSHAKE=1, FETCH/MEM_READ/MEM_WRITE hold until mem_ready; outputs are stable while waiting.
//
// Ports:
//   clk, reset               - clock, synchronous active-high reset (returns to FETCH, gates all enables)
//   opcode/funct3/funct7     - instruction register fields
//   zero/less_than/signed_less_than - ALU flags for branch resolution
//   mem_ready                - memory access completes this cycle
//   pc_write/ir_write/reg_write/mem_write/mem_req - datapath enables
//   adr_src/alu_src_a/alu_src_b/result_src/alu_control/imm_src - datapath selects
//   instr_done               - one-cycle retire pulse; illegal_instr - illegal instruction flag
module mc_control_fsm #(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       less_than,
    input  logic       signed_less_than,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_req,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] alu_control,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_LUI, S_AUIPC, S_JAL,
        S_JALR_ADR, S_JALR_JMP, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t state, state_next;
    logic   rdy;
    logic   funct_legal;
    logic   taken;

    // Without the handshake every memory state completes in one cycle.
    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // funct7 must be all-zero, or 0100000 only for SUB/SRA(I) (funct3 000/101).
    // For I-type only the shifts carry a funct7 field, so this is consulted there for 001/101 only.
    assign funct_legal = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5, input logic is_r);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = 4'b0101;
            3'b010:  code = 4'b1000;
            3'b011:  code = 4'b1001;
            3'b100:  code = 4'b0100;
            3'b101:  code = f7b5 ? 4'b0111 : 4'b0110;
            3'b110:  code = 4'b0011;
            default: code = 4'b0010;
        endcase
        return code;
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = signed_less_than;
            3'b101:  taken = !signed_less_than;
            3'b110:  taken = less_than;
            3'b111:  taken = !less_than;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LOAD, OP_I, OP_JALR: imm_src = 3'b000;
            OP_STORE:               imm_src = 3'b001;
            OP_BRANCH:              imm_src = 3'b010;
            OP_JAL:                 imm_src = 3'b011;
            OP_LUI, OP_AUIPC:       imm_src = 3'b100;
            default:                imm_src = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_write     = 1'b0;
        mem_req       = 1'b0;
        adr_src       = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_control   = ALU_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = rdy;
                pc_write   = rdy;
                if (rdy) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC-relative target into ALUOut for branch/JAL.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = (funct3 == 3'b000) ? S_JALR_ADR : S_TRAP;
                    OP_BRANCH:         state_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                // Loads and stores differ only in opcode bit 5.
                state_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                adr_src = 1'b1;
                mem_req = 1'b1;
                if (rdy) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                adr_src    = 1'b1;
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                instr_done = rdy;
                if (rdy) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(funct3, funct7[5], 1'b1);
                state_next  = funct_legal ? S_ALU_WB : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(funct3, funct7[5], 1'b0);
                if ((funct3 == 3'b001 || funct3 == 3'b101) && !funct_legal) begin
                    state_next = S_TRAP;
                end else begin
                    state_next = S_ALU_WB;
                end
            end
            S_LUI: begin
                alu_src_a  = 2'b11;
                alu_src_b  = 2'b01;
                state_next = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL, S_JALR_JMP: begin
                // Link value old_pc+4 goes to ALUOut while PC takes the target.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALU_WB;
            end
            S_JALR_ADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = S_JALR_JMP;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                pc_write    = taken;
                instr_done  = 1'b1;
                state_next  = S_FETCH;
            end
            default: begin
                illegal_instr = 1'b1;
                state_next    = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
        endcase

        // Reset aborts any in-flight access: no writes, requests or retire pulses.
        if (reset) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            mem_write  = 1'b0;
            mem_req    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, less_than, signed_less_than, mem_ready;

    logic       h_pc_write, h_ir_write, h_reg_write, h_mem_write, h_mem_req, h_adr_src;
    logic [1:0] h_a, h_b, h_rs;
    logic [3:0] h_alu;
    logic [2:0] h_imm;
    logic       h_done, h_ill;

    logic       n_pc_write, n_ir_write, n_reg_write, n_mem_write, n_mem_req, n_adr_src;
    logic [1:0] n_a, n_b, n_rs;
    logic [3:0] n_alu;
    logic [2:0] n_imm;
    logic       n_done, n_ill;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_ON_ILLEGAL(1'b1)) u_dut_hs (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .less_than(less_than), .signed_less_than(signed_less_than), .mem_ready(mem_ready),
        .pc_write(h_pc_write), .ir_write(h_ir_write), .reg_write(h_reg_write), .mem_write(h_mem_write),
        .mem_req(h_mem_req), .adr_src(h_adr_src), .alu_src_a(h_a), .alu_src_b(h_b), .result_src(h_rs),
        .alu_control(h_alu), .imm_src(h_imm), .instr_done(h_done), .illegal_instr(h_ill)
    );

    mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ON_ILLEGAL(1'b0)) u_dut_nohs (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .less_than(less_than), .signed_less_than(signed_less_than), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .ir_write(n_ir_write), .reg_write(n_reg_write), .mem_write(n_mem_write),
        .mem_req(n_mem_req), .adr_src(n_adr_src), .alu_src_a(n_a), .alu_src_b(n_b), .result_src(n_rs),
        .alu_control(n_alu), .imm_src(n_imm), .instr_done(n_done), .illegal_instr(n_ill)
    );

    typedef struct packed {
        logic       pc_write, ir_write, reg_write, mem_write, mem_req, adr_src;
        logic [1:0] a, b, rs;
        logic [3:0] alu;
        logic [2:0] imm;
        logic       done, ill;
    } obs_t;

    // sel: 1 = handshake/sticky-trap instance, 0 = no-handshake/pulse-trap instance.
    typedef struct packed {
        logic sel;
        logic rdy;
        obs_t e;
    } item_t;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEM_ADR, T_MEM_READ, T_MEM_WB, T_MEM_WRITE, T_EXEC_R, T_EXEC_I,
        T_ALU_WB, T_LUI, T_AUIPC, T_JAL, T_JALR_ADR, T_JALR_JMP, T_BRANCH, T_TRAP
    } tst_e;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    logic [3:0] r_tab [8]  = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0011, 4'b0010};
    logic [2:0] br_f3 [6]  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    logic       br_t1 [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       br_t2 [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
            7'b0100011:                         return 3'b001;
            7'b1100011:                         return 3'b010;
            7'b1101111:                         return 3'b011;
            7'b0110111, 7'b0010111:             return 3'b100;
            default:                            return 3'b000;
        endcase
    endfunction

    // Expected output vector for one state; f = mem_ready/completion for memory states, taken for BRANCH.
    function automatic obs_t ex(input tst_e s, input logic [6:0] op, input logic [3:0] alu, input logic f);
        obs_t o = '0;
        o.imm = imm_of(op);
        case (s)
            T_FETCH:     begin o.mem_req = 1; o.b = 2'b10; o.rs = 2'b10; o.ir_write = f; o.pc_write = f; end
            T_DECODE:    begin o.a = 2'b01; o.b = 2'b01; end
            T_MEM_ADR:   begin o.a = 2'b10; o.b = 2'b01; end
            T_MEM_READ:  begin o.adr_src = 1; o.mem_req = 1; end
            T_MEM_WB:    begin o.rs = 2'b01; o.reg_write = 1; o.done = 1; end
            T_MEM_WRITE: begin o.adr_src = 1; o.mem_req = 1; o.mem_write = 1; o.done = f; end
            T_EXEC_R:    begin o.a = 2'b10; o.alu = alu; end
            T_EXEC_I:    begin o.a = 2'b10; o.b = 2'b01; o.alu = alu; end
            T_LUI:       begin o.a = 2'b11; o.b = 2'b01; end
            T_AUIPC:     begin o.a = 2'b01; o.b = 2'b01; end
            T_ALU_WB:    begin o.reg_write = 1; o.done = 1; end
            T_JAL:       begin o.a = 2'b01; o.b = 2'b10; o.pc_write = 1; end
            T_JALR_ADR:  begin o.a = 2'b10; o.b = 2'b01; end
            T_JALR_JMP:  begin o.a = 2'b01; o.b = 2'b10; o.pc_write = 1; end
            T_BRANCH:    begin o.a = 2'b10; o.alu = 4'b0001; o.pc_write = f; o.done = 1; end
            default:     begin o.ill = 1; end
        endcase
        return o;
    endfunction

    function automatic obs_t gate_rst(input obs_t i);
        obs_t o = i;
        o.pc_write = 0; o.ir_write = 0; o.reg_write = 0; o.mem_write = 0; o.mem_req = 0; o.done = 0;
        return o;
    endfunction

    function automatic obs_t get_obs(input logic sel);
        if (sel) return {h_pc_write, h_ir_write, h_reg_write, h_mem_write, h_mem_req, h_adr_src,
                         h_a, h_b, h_rs, h_alu, h_imm, h_done, h_ill};
        return {n_pc_write, n_ir_write, n_reg_write, n_mem_write, n_mem_req, n_adr_src,
                n_a, n_b, n_rs, n_alu, n_imm, n_done, n_ill};
    endfunction

    task automatic push(input logic sel, input logic rdy, input obs_t e);
        sb.push_back('{sel: sel, rdy: rdy, e: e});
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    // Entered and left at posedge+1; one queued item per clock, compared at the falling edge.
    task automatic run(input string tag);
        item_t it;
        obs_t  got;
        int    cyc = 0;
        while (sb.size() > 0) begin
            mem_ready = sb[0].rdy;
            @(negedge clk);
            it  = sb.pop_front();
            got = get_obs(it.sel);
            checks++;
            assert (got === it.e) else begin
                errors++;
                $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, it.e);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Four-state ALU-class sequence on the handshake instance.
    task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input tst_e xs, input logic [3:0] alu);
        set_ir(op, f3, f7);
        push(1, 1, ex(T_FETCH, op, 0, 1));
        push(1, 1, ex(T_DECODE, op, 0, 0));
        push(1, 1, ex(xs, op, alu, 0));
        push(1, 1, ex(T_ALU_WB, op, 0, 0));
        run(tag);
    endtask

    initial begin
        reset = 1'b1; zero = 0; less_than = 0; signed_less_than = 0; mem_ready = 0;
        set_ir(7'h00, 3'h0, 7'h00);
        repeat (2) @(posedge clk);
        #1;
        push(1, 0, gate_rst(ex(T_FETCH, 7'h00, 0, 0)));
        push(0, 1, gate_rst(ex(T_FETCH, 7'h00, 0, 1)));
        run("reset_state");
        reset = 1'b0;

        alu_instr("r_add", 7'b0110011, 3'b000, 7'b0000000, T_EXEC_R, 4'b0000);
        for (int k = 0; k < 8; k++) alu_instr("r_funct3", 7'b0110011, 3'(k), 7'b0000000, T_EXEC_R, r_tab[k]);
        alu_instr("r_sub", 7'b0110011, 3'b000, 7'b0100000, T_EXEC_R, 4'b0001);
        alu_instr("r_sra", 7'b0110011, 3'b101, 7'b0100000, T_EXEC_R, 4'b0111);
        alu_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, T_EXEC_I, 4'b0000);
        alu_instr("srai", 7'b0010011, 3'b101, 7'b0100000, T_EXEC_I, 4'b0111);
        alu_instr("srli", 7'b0010011, 3'b101, 7'b0000000, T_EXEC_I, 4'b0110);
        alu_instr("sltiu_imm", 7'b0010011, 3'b011, 7'b0100101, T_EXEC_I, 4'b1001);
        alu_instr("lui", 7'b0110111, 3'b000, 7'b0000000, T_LUI, 4'b0000);
        alu_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, T_AUIPC, 4'b0000);

        // Load with three wait cycles in MEM_READ; mem_ready low in DECODE/MEM_ADR is ignored.
        set_ir(7'b0000011, 3'b010, 7'h00);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 0, ex(T_DECODE, opcode, 0, 0));
        push(1, 0, ex(T_MEM_ADR, opcode, 0, 0));
        repeat (3) push(1, 0, ex(T_MEM_READ, opcode, 0, 0));
        push(1, 1, ex(T_MEM_READ, opcode, 0, 0));
        push(1, 1, ex(T_MEM_WB, opcode, 0, 0));
        run("load_wait");

        // Store with one fetch wait and one write wait.
        set_ir(7'b0100011, 3'b010, 7'h00);
        push(1, 0, ex(T_FETCH, opcode, 0, 0));
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 0, ex(T_DECODE, opcode, 0, 0));
        push(1, 1, ex(T_MEM_ADR, opcode, 0, 0));
        push(1, 0, ex(T_MEM_WRITE, opcode, 0, 0));
        push(1, 1, ex(T_MEM_WRITE, opcode, 0, 1));
        run("store_wait");

        for (int pass = 0; pass < 2; pass++) begin
            zero = (pass == 0); less_than = (pass == 1); signed_less_than = 1'b0;
            for (int k = 0; k < 6; k++) begin
                set_ir(7'b1100011, br_f3[k], 7'h00);
                push(1, 1, ex(T_FETCH, opcode, 0, 1));
                push(1, 1, ex(T_DECODE, opcode, 0, 0));
                push(1, 1, ex(T_BRANCH, opcode, 0, (pass == 0) ? br_t1[k] : br_t2[k]));
                run(pass == 0 ? "branch_zero" : "branch_lt");
            end
        end

        set_ir(7'b1101111, 3'b000, 7'h00);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 1, ex(T_DECODE, opcode, 0, 0));
        push(1, 1, ex(T_JAL, opcode, 0, 0));
        push(1, 1, ex(T_ALU_WB, opcode, 0, 0));
        run("jal");

        set_ir(7'b1100111, 3'b000, 7'h00);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 1, ex(T_DECODE, opcode, 0, 0));
        push(1, 1, ex(T_JALR_ADR, opcode, 0, 0));
        push(1, 1, ex(T_JALR_JMP, opcode, 0, 0));
        push(1, 1, ex(T_ALU_WB, opcode, 0, 0));
        run("jalr");

        // Bad funct7 on R-type parks the sticky instance in TRAP.
        set_ir(7'b0110011, 3'b000, 7'b0000001);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 1, ex(T_DECODE, opcode, 0, 0));
        push(1, 1, ex(T_EXEC_R, opcode, 4'b0000, 0));
        repeat (3) push(1, 1, ex(T_TRAP, opcode, 0, 0));
        run("r_bad_f7");
        pulse_reset();

        set_ir(7'b1111111, 3'b000, 7'h00);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 1, ex(T_DECODE, opcode, 0, 0));
        repeat (20) push(1, 1, ex(T_TRAP, opcode, 0, 0));
        run("trap_sticky");
        pulse_reset();

        // Reset in MEM_READ: enables gated while reset is high, FETCH right after.
        set_ir(7'b0000011, 3'b000, 7'h00);
        push(1, 1, ex(T_FETCH, opcode, 0, 1));
        push(1, 1, ex(T_DECODE, opcode, 0, 0));
        push(1, 1, ex(T_MEM_ADR, opcode, 0, 0));
        push(1, 0, ex(T_MEM_READ, opcode, 0, 0));
        run("pre_abort");
        reset = 1'b1;
        push(1, 1, gate_rst(ex(T_MEM_READ, opcode, 0, 0)));
        run("reset_abort");
        reset = 1'b0;
        alu_instr("after_abort", 7'b0110011, 3'b100, 7'b0000000, T_EXEC_R, 4'b0100);

        // No-handshake, non-sticky instance: mem_ready held low throughout.
        pulse_reset();
        set_ir(7'b1111111, 3'b000, 7'h00);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_TRAP, opcode, 0, 0));
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        run("trap_pulse");
        pulse_reset();

        set_ir(7'b0000011, 3'b000, 7'h00);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_MEM_ADR, opcode, 0, 0));
        push(0, 0, ex(T_MEM_READ, opcode, 0, 0));
        push(0, 0, ex(T_MEM_WB, opcode, 0, 0));
        run("nohs_load");

        set_ir(7'b0100011, 3'b000, 7'h00);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_MEM_ADR, opcode, 0, 0));
        push(0, 0, ex(T_MEM_WRITE, opcode, 0, 1));
        run("nohs_store");

        set_ir(7'b0010011, 3'b001, 7'b0000001);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_EXEC_I, opcode, 4'b0101, 0));
        push(0, 0, ex(T_TRAP, opcode, 0, 0));
        run("slli_bad_f7");

        set_ir(7'b0110011, 3'b001, 7'b0100000);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_EXEC_R, opcode, 4'b0101, 0));
        push(0, 0, ex(T_TRAP, opcode, 0, 0));
        run("r_f7_f3_bad");

        set_ir(7'b1100111, 3'b001, 7'h00);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_TRAP, opcode, 0, 0));
        run("jalr_bad_f3");

        set_ir(7'b1100011, 3'b010, 7'h00);
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        push(0, 0, ex(T_DECODE, opcode, 0, 0));
        push(0, 0, ex(T_TRAP, opcode, 0, 0));
        push(0, 0, ex(T_FETCH, opcode, 0, 1));
        run("branch_bad_f3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
